// File: rtl/snn_pkg.sv
// Shared constants and state encoding for the SNN image loader.
package snn_pkg;

    localparam int NUM_PIXELS = 784;
    localparam int ADDR_W     = 10;
    localparam logic [7:0] ASCII_BASE = 8'h30;

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NUM_PIXELS - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    typedef enum logic [2:0] {
        LOAD      = 3'd0,
        UNPACK    = 3'd1,
        START     = 3'd2,
        WAIT_CORE = 3'd3,
        TX        = 3'd4
    } loader_state_t;

    function automatic logic [7:0] digit_to_ascii(input logic [3:0] digit);
        return ASCII_BASE + {4'b0000, digit};
    endfunction

endpackage

// File: rtl/byte_unpacker.sv
// One-byte hold buffer feeding an 8-bit LSB-first shift register; flags dropped bytes.
module byte_unpacker (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_rdy,
    input  logic       accept_en,
    input  logic       load,
    input  logic       shift,
    input  logic       ovr_clr,
    output logic       hold_full,
    output logic       bit_out,
    output logic       last_bit,
    output logic       overrun
);

    logic [7:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       overrun_q, overrun_d;
    logic       take_s, drop_s;

    // Next-state for hold, shift and overrun; a load frees the hold slot in the same cycle.
    always_comb begin
        take_s = rx_rdy & accept_en & (~hold_full_q | load);
        drop_s = rx_rdy & ~take_s;

        if (take_s) begin
            hold_d      = rx_data;
            hold_full_d = 1'b1;
        end else if (load) begin
            hold_d      = hold_q;
            hold_full_d = 1'b0;
        end else begin
            hold_d      = hold_q;
            hold_full_d = hold_full_q;
        end

        if (load) begin
            shift_d   = hold_q;
            bit_cnt_d = 3'd0;
        end else if (shift) begin
            shift_d   = {1'b0, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
        end else begin
            shift_d   = shift_q;
            bit_cnt_d = bit_cnt_q;
        end

        overrun_d = (overrun_q & ~ovr_clr) | drop_s;
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            shift_q     <= 8'h00;
            bit_cnt_q   <= 3'd0;
            overrun_q   <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            overrun_q   <= overrun_d;
        end
    end

    assign hold_full = hold_full_q;
    assign bit_out   = shift_q[0];
    assign last_bit  = (bit_cnt_q == 3'd7);
    assign overrun   = overrun_q;

endmodule

// File: rtl/snn_image_loader.sv
// Loads a packed 28x28 binary image into the input RAM, runs snn_core, returns the digit as ASCII.
module snn_image_loader
    import snn_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_rdy,
    output logic              ram_d,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    input  logic [ADDR_W-1:0] core_addr,
    output logic              snn_start,
    input  logic              snn_done,
    input  logic [3:0]        snn_digit,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic [3:0]        digit_out,
    output logic              overrun
);

    loader_state_t     state_q, state_d;
    logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
    logic              ram_we_q, ram_we_d;
    logic              snn_start_q, snn_start_d;
    logic              tx_start_q, tx_start_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [3:0]        digit_out_q, digit_out_d;

    logic accept_en_s, load_s, shift_s, ovr_clr_s;
    logic hold_full_s, bit_out_s, last_bit_s, overrun_s;

    byte_unpacker u_unpacker (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_rdy    (rx_rdy),
        .accept_en (accept_en_s),
        .load      (load_s),
        .shift     (shift_s),
        .ovr_clr   (ovr_clr_s),
        .hold_full (hold_full_s),
        .bit_out   (bit_out_s),
        .last_bit  (last_bit_s),
        .overrun   (overrun_s)
    );

    // Loader FSM next-state; ram_we_d/snn_start_d describe the cycle after this one.
    always_comb begin
        state_d     = state_q;
        pix_cnt_d   = pix_cnt_q;
        ram_we_d    = 1'b0;
        snn_start_d = 1'b0;
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;
        digit_out_d = digit_out_q;
        load_s      = 1'b0;
        shift_s     = 1'b0;
        ovr_clr_s   = 1'b0;
        accept_en_s = (state_q == LOAD) || (state_q == UNPACK);

        case (state_q)
            LOAD: begin
                if (hold_full_s) begin
                    load_s   = 1'b1;
                    ram_we_d = 1'b1;
                    state_d  = UNPACK;
                end else begin
                    state_d  = LOAD;
                end
            end
            UNPACK: begin
                // Saturate so a full frame leaves the counter parked on the last pixel.
                if (pix_cnt_q != LAST_PIX) begin
                    pix_cnt_d = pix_cnt_q + ADDR_ONE;
                end else begin
                    pix_cnt_d = pix_cnt_q;
                end
                if (!last_bit_s) begin
                    shift_s  = 1'b1;
                    ram_we_d = 1'b1;
                end else if (pix_cnt_q == LAST_PIX) begin
                    shift_s     = 1'b1;
                    snn_start_d = 1'b1;
                    state_d     = START;
                end else if (hold_full_s) begin
                    load_s   = 1'b1;
                    ram_we_d = 1'b1;
                end else begin
                    shift_s  = 1'b1;
                    state_d  = LOAD;
                end
            end
            START: begin
                pix_cnt_d = {ADDR_W{1'b0}};
                ovr_clr_s = 1'b1;
                state_d   = WAIT_CORE;
            end
            WAIT_CORE: begin
                if (snn_done) begin
                    digit_out_d = snn_digit;
                    state_d     = TX;
                end else begin
                    state_d     = WAIT_CORE;
                end
            end
            TX: begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = digit_to_ascii(digit_out_q);
                    state_d    = LOAD;
                end else begin
                    state_d    = TX;
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    // The core owns the RAM address only while it is classifying.
    always_comb begin
        if (state_q == WAIT_CORE) begin
            ram_addr = core_addr;
        end else begin
            ram_addr = pix_cnt_q;
        end
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            pix_cnt_q   <= {ADDR_W{1'b0}};
            ram_we_q    <= 1'b0;
            snn_start_q <= 1'b0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            digit_out_q <= 4'h0;
        end else begin
            state_q     <= state_d;
            pix_cnt_q   <= pix_cnt_d;
            ram_we_q    <= ram_we_d;
            snn_start_q <= snn_start_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            digit_out_q <= digit_out_d;
        end
    end

    assign ram_d     = bit_out_s;
    assign ram_we    = ram_we_q;
    assign snn_start = snn_start_q;
    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign digit_out = digit_out_q;
    assign overrun   = overrun_s;

endmodule

// File: tb/tb_snn_image_loader.sv
// Directed bench for snn_image_loader with a queue-based pixel-write model.
module tb_snn_image_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_rdy;
    logic       ram_d;
    logic [9:0] ram_addr;
    logic       ram_we;
    logic [9:0] core_addr;
    logic       snn_start;
    logic       snn_done;
    logic [3:0] snn_digit;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic [3:0] digit_out;
    logic       overrun;

    snn_image_loader dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_rdy(rx_rdy),
        .ram_d(ram_d), .ram_addr(ram_addr), .ram_we(ram_we), .core_addr(core_addr),
        .snn_start(snn_start), .snn_done(snn_done), .snn_digit(snn_digit),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .digit_out(digit_out), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] addr;
        logic       d;
    } wr_t;

    wr_t        exp_q[$];
    logic [9:0] model_addr = 10'd0;
    logic       img [0:1023];

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    int wr_cnt = 0, first_we_cyc = 0, last_we_cyc = 0;
    int start_cnt = 0, start_cyc = 0, tx_cnt = 0, tx_cyc = 0;
    int cap_cyc = 0, d_cyc = 0, fall_cyc = 0;
    logic [9:0] first_we_addr = 10'd0, last_we_addr = 10'd0;
    logic [7:0] tx_seen = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: a received byte becomes 8 writes at consecutive addresses, LSB first, wrapping per frame.
    task automatic push_byte(input logic [7:0] b);
        wr_t w;
        for (int i = 0; i < 8; i++) begin
            w.addr = model_addr;
            w.d    = b[3'(i)];
            exp_q.push_back(w);
            if (model_addr == 10'd783) model_addr = 10'd0;
            else model_addr = model_addr + 10'd1;
        end
    endtask

    function automatic logic [7:0] img_byte(input int k);
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[3'(i)] = img[10'(8 * k + i)];
        return v;
    endfunction

    function automatic logic [7:0] ascii_of(input int d);
        return 8'(48 + d);
    endfunction

    function automatic logic [7:0] pattern(input int k);
        return 8'(k * 37) ^ 8'h5A;
    endfunction

    task automatic clr_obs();
        wr_cnt = 0; start_cnt = 0; tx_cnt = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        model_addr = 10'd0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        clr_obs();
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data = b; rx_rdy = 1'b1;
        @(posedge clk); #1;
        cap_cyc = cyc; rx_rdy = 1'b0;
    endtask

    task automatic wait_writes(input string nm, input int n, input int budget);
        for (int i = 0; i < budget && wr_cnt < n; i++) @(posedge clk);
        repeat (4) @(posedge clk);
        chk(nm, 32'(wr_cnt), 32'(n));
    endtask

    task automatic wait_start();
        for (int i = 0; i < 60 && start_cnt == 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        chk("start_once", 32'(start_cnt), 32'd1);
        chk("start_after_last_write", 32'(start_cyc), 32'(last_we_cyc + 1));
    endtask

    task automatic pulse_done(input logic [3:0] d);
        @(posedge clk); #1;
        snn_digit = d; snn_done = 1'b1;
        @(posedge clk); #1;
        d_cyc = cyc; snn_done = 1'b0; snn_digit = 4'h0;
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_ram_d"},     32'(ram_d), 32'd0);
        chk({nm, "_ram_addr"},  32'(ram_addr), 32'd0);
        chk({nm, "_ram_we"},    32'(ram_we), 32'd0);
        chk({nm, "_snn_start"}, 32'(snn_start), 32'd0);
        chk({nm, "_tx_data"},   32'(tx_data), 32'd0);
        chk({nm, "_tx_start"},  32'(tx_start), 32'd0);
        chk({nm, "_digit_out"}, 32'(digit_out), 32'd0);
        chk({nm, "_overrun"},   32'(overrun), 32'd0);
    endtask

    // Compare process: every RAM write must match the head of the model queue.
    initial begin
        wr_t w;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (ram_we === 1'b1) begin
                    if (wr_cnt == 0) begin
                        first_we_cyc  = cyc;
                        first_we_addr = ram_addr;
                    end
                    wr_cnt++;
                    last_we_cyc  = cyc;
                    last_we_addr = ram_addr;
                    img[ram_addr] = ram_d;
                    chk("wr_range", 32'(ram_addr <= 10'd783), 32'd1);
                    chk("wr_pending", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        w = exp_q.pop_front();
                        chk("wr_addr", 32'(ram_addr), 32'(w.addr));
                        chk("wr_data", 32'(ram_d), 32'(w.d));
                    end
                end
                if (snn_start === 1'b1) begin
                    start_cnt++;
                    start_cyc = cyc;
                end
                if (tx_start === 1'b1) begin
                    tx_cnt++;
                    tx_cyc  = cyc;
                    tx_seen = tx_data;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic hit;
        rst_n = 1'b0; rx_data = 8'h00; rx_rdy = 1'b0; core_addr = 10'h000;
        snn_done = 1'b0; snn_digit = 4'h0; tx_busy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        do_reset();

        // Single byte A5
        push_byte(8'hA5);
        send_byte(8'hA5);
        wait_writes("a5_count", 8, 40);
        chk("a5_latency", 32'(first_we_cyc), 32'(cap_cyc + 1));
        chk("a5_contiguous", 32'(last_we_cyc - first_we_cyc), 32'd7);
        chk("a5_pixels", 32'(img_byte(0)), 32'h0000_00A5);
        chk("a5_overrun", 32'(overrun), 32'd0);
        chk("a5_drain", 32'(exp_q.size()), 32'd0);

        // Back-to-back: second byte two cycles after the first
        do_reset();
        push_byte(8'hA5); push_byte(8'h3C);
        @(posedge clk); #1 rx_data = 8'hA5; rx_rdy = 1'b1;
        @(posedge clk); #1 rx_rdy = 1'b0;
        @(posedge clk); #1 rx_data = 8'h3C; rx_rdy = 1'b1;
        @(posedge clk); #1 rx_rdy = 1'b0;
        wait_writes("b2b_count", 16, 40);
        chk("b2b_no_bubble", 32'(last_we_cyc - first_we_cyc), 32'd15);
        chk("b2b_byte1", 32'(img_byte(1)), 32'h0000_003C);
        chk("b2b_overrun", 32'(overrun), 32'd0);

        // Overrun: three pulses in consecutive cycles, third dropped
        do_reset();
        push_byte(8'h11); push_byte(8'h22);
        @(posedge clk); #1 rx_data = 8'h11; rx_rdy = 1'b1;
        @(posedge clk); #1 rx_data = 8'h22;
        @(posedge clk); #1 rx_data = 8'h33;
        @(posedge clk); #1 rx_rdy = 1'b0;
        wait_writes("ovr_count", 16, 40);
        repeat (20) @(posedge clk);
        chk("ovr_count_final", 32'(wr_cnt), 32'd16);
        chk("ovr_flag", 32'(overrun), 32'd1);
        chk("ovr_byte1", 32'(img_byte(1)), 32'h0000_0022);
        chk("ovr_drain", 32'(exp_q.size()), 32'd0);

        // Full frame of 0xFF bytes, 20 cycles apart
        do_reset();
        for (int k = 0; k < 98; k++) begin
            push_byte(8'hFF);
            send_byte(8'hFF);
            repeat (18) @(posedge clk);
        end
        wait_start();
        chk("frame_writes", 32'(wr_cnt), 32'd784);
        chk("frame_last_addr", 32'(last_we_addr), 32'd783);
        chk("frame_overrun", 32'(overrun), 32'd0);
        chk("frame_drain", 32'(exp_q.size()), 32'd0);

        // Core handoff and immediate transmit
        @(posedge clk); #1 core_addr = 10'h123;
        @(negedge clk);
        chk("handoff_addr", 32'(ram_addr), 32'h0000_0123);
        chk("handoff_we", 32'(ram_we), 32'd0);
        pulse_done(4'd7);
        repeat (4) @(posedge clk);
        chk("tx7_count", 32'(tx_cnt), 32'd1);
        chk("tx7_latency", 32'(tx_cyc), 32'(d_cyc + 1));
        chk("tx7_data", 32'(tx_seen), 32'h0000_0037);
        chk("tx7_model", 32'(tx_seen), 32'(ascii_of(7)));
        chk("tx7_digit", 32'(digit_out), 32'd7);

        // snn_done outside WAIT_CORE is ignored
        clr_obs();
        pulse_done(4'd3);
        repeat (4) @(posedge clk);
        chk("stray_done_digit", 32'(digit_out), 32'd7);
        chk("stray_done_tx", 32'(tx_cnt), 32'd0);

        // Second frame without reset, then transmit backpressure
        clr_obs();
        for (int k = 0; k < 98; k++) begin
            push_byte(pattern(k));
            send_byte(pattern(k));
            repeat (8) @(posedge clk);
        end
        wait_start();
        chk("frame2_first_addr", 32'(first_we_addr), 32'd0);
        chk("frame2_byte50", 32'(img_byte(50)), 32'h0000_0060);
        chk("frame2_byte97", 32'(img_byte(97)), 32'h0000_005F);
        chk("frame2_drain", 32'(exp_q.size()), 32'd0);
        tx_busy = 1'b1;
        pulse_done(4'd9);
        repeat (50) @(posedge clk);
        chk("busy_hold", 32'(tx_cnt), 32'd0);
        #1 tx_busy = 1'b0;
        fall_cyc = cyc;
        repeat (4) @(posedge clk);
        chk("busy_release_count", 32'(tx_cnt), 32'd1);
        chk("busy_release_latency", 32'(tx_cyc), 32'(fall_cyc + 1));
        chk("tx9_data", 32'(tx_seen), 32'(ascii_of(9)));
        chk("tx9_digit", 32'(digit_out), 32'd9);

        // Reset in the middle of unpacking pixel 300
        clr_obs();
        for (int k = 0; k < 37; k++) begin
            push_byte(8'h96);
            send_byte(8'h96);
            repeat (8) @(posedge clk);
        end
        push_byte(8'h96);
        send_byte(8'h96);
        hit = 1'b0;
        for (int i = 0; i < 30 && !hit; i++) begin
            @(negedge clk);
            if (ram_we === 1'b1 && ram_addr == 10'd300) hit = 1'b1;
        end
        chk("mid_reset_reached", 32'(hit), 32'd1);
        rst_n = 1'b0;
        exp_q.delete();
        model_addr = 10'd0;
        #1;
        chk_reset_outputs("mid_reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        clr_obs();
        push_byte(8'hC3);
        send_byte(8'hC3);
        wait_writes("post_reset_count", 8, 40);
        chk("post_reset_addr0", 32'(first_we_addr), 32'd0);
        chk("post_reset_latency", 32'(first_we_cyc), 32'(cap_cyc + 1));
        chk("post_reset_pixels", 32'(img_byte(0)), 32'h0000_00C3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/snn_image_loader.md
Name: snn_image_loader

Overview:
- Writer side of the input-image RAM (ram_input_unit, 1-bit × 784) that snn_core reads.
- Receives a 28×28 binary image as 98 packed bytes from the UART receiver and unpacks them into 784 single-bit RAM writes.
- Pulses snn_core start, owns the RAM address mux while the core runs, waits for done, then sends the classified digit back as one ASCII byte through the UART transmitter.

Parameters:
- NUM_PIXELS, 784, pixels per image; the RAM depth.
- ADDR_W, 10, RAM address width.
- ASCII_BASE, 8'h30, offset added to digit for transmission.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- rx_data  in  8  received byte; valid when rx_rdy=1.
- rx_rdy  in  1  one-cycle pulse, byte available.
- ram_d  out  1  pixel bit to ram_input_unit.
- ram_addr  out  ADDR_W  ram_input_unit address (muxed).
- ram_we  out  1  ram_input_unit write enable.
- core_addr  in  ADDR_W  snn_core addr_input_unit.
- snn_start  out  1  one-cycle start pulse to snn_core.
- snn_done  in  1  snn_core done pulse.
- snn_digit  in  4  snn_core digit; valid with snn_done.
- tx_data  out  8  byte to UART transmitter.
- tx_start  out  1  one-cycle transmit request.
- tx_busy  in  1  transmitter busy.
- digit_out  out  4  last classified digit, held.
- overrun  out  1  sticky, a received byte was dropped.

Behaviour:
- Reset values: ram_d=0, ram_addr=0, ram_we=0, snn_start=0, tx_data=0, tx_start=0, digit_out=0, overrun=0. State is LOAD. The pixel counter and the hold register are cleared.
- Reset mid-operation aborts everything. The next image starts at addr 0.
- Pixel mapping: byte k, bit i (LSB first) goes to addr 8k+i. Byte 0 is pixels 0..7. Byte 97 bit 7 is pixel 783.
- Hold register: one byte plus a hold_full flag.
  - rx_rdy with hold_full=0 captures rx_data and sets hold_full.
  - rx_rdy with hold_full=1, or rx_rdy outside LOAD/UNPACK, drops the byte and sets overrun.
- States:
  - LOAD: ram_addr=pix_cnt, ram_we=0. If hold_full, move the hold byte to the shift register, clear hold_full, go to UNPACK.
  - UNPACK: ram_we=1, ram_d=shift[0], ram_addr=pix_cnt. Each cycle shift right and increment pix_cnt. After 8 writes:
    - if pix_cnt has reached NUM_PIXELS, go to START;
    - else if hold_full, reload the shift register and stay in UNPACK with no bubble;
    - else go to LOAD.
  - START: snn_start=1 for exactly one cycle, ram_we=0, clear pix_cnt, go to WAIT_CORE. overrun is cleared here, at the start of each new frame.
  - WAIT_CORE: ram_addr=core_addr combinationally, ram_we=0. On snn_done, latch snn_digit into digit_out and go to TX.
  - TX: wait while tx_busy=1. When tx_busy=0, drive tx_data=ASCII_BASE+digit_out and tx_start=1 for one cycle, then go to LOAD.
- Latency:
  - Byte captured at edge N: first RAM write is in the cycle after N+1, followed by 8 consecutive write cycles.
  - 784th write at cycle W: snn_start is high in cycle W+1.
  - snn_done at edge D: tx_start no earlier than D+1 (exactly D+1 if tx_busy=0).
- ram_addr never exceeds NUM_PIXELS-1 while ram_we=1. pix_cnt saturates, it never wraps mid-frame.
- snn_done outside WAIT_CORE is ignored.
- Arithmetic: tx_data = ASCII_BASE + {4'b0, digit_out}, 8-bit, no overflow for digits 0..9.

Decomposition:
- Shared package snn_pkg:
  - NUM_PIXELS, ADDR_W, ASCII_BASE;
  - loader_state_t enum {LOAD, UNPACK, START, WAIT_CORE, TX}.
- One natural sub-module: byte_unpacker.
  - Contents: hold register, shift register, 3-bit bit counter, overrun logic.
  - Interface: load/valid handshake, one bit out per cycle.
  - FSM, pixel counter and address mux stay in the top module.

Test Plan:
- Single-byte unpack: reset, rx_rdy with 8'hA5 → ram_we high 8 cycles; addr 0..7 carry ram_d = 1,0,1,0,0,1,0,1.
- Full frame: 98 bytes, all 8'hFF, spaced 20 cycles → 784 writes; last write addr 783; snn_start pulses once the cycle after; overrun=0.
- Back-to-back bytes: second rx_rdy arrives 2 cycles after the first → second byte held, written at addr 8..15 with no idle cycle; overrun=0.
- Overrun: three rx_rdy pulses in consecutive cycles → third byte dropped; overrun=1; only 16 pixels written.
- Core handoff: in WAIT_CORE drive core_addr=10'h123 → ram_addr=10'h123, ram_we=0. snn_done with snn_digit=7 and tx_busy=0 → tx_data=8'h37 with a 1-cycle tx_start; digit_out=7.
- TX backpressure and reset: tx_busy held 50 cycles → tx_start waits until tx_busy falls. Asserting rst_n low mid-UNPACK at pixel 300 → all outputs return to reset values; the next byte writes addr 0..7.
